wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register; it takes the registered WriteBack-stage fields.
- Selects and formats the writeback result, including load byte/halfword extraction and sign/zero extension.
- Commits the result into the 32-entry integer register file and serves the two Decode-stage read ports, with same-cycle write-through bypass.
- Keeps a retired-instruction counter.

Parameters:
- BYPASS, 1, 1 = a read of the register being written this cycle returns ResultW; 0 = the read returns the old array contents.
- INSTRET_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ValidW  input  1  a real instruction occupies WB this cycle; low for a bubble
- RegWriteW  input  1  the instruction writes rd
- ResultSrcW  input  2  00 ALU, 01 load data, 10 PC+4, 11 ALU (reserved)
- LoadFunct3W  input  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- ALUResultW  input  32  ALU result / load effective address
- ReadDataW  input  32  raw aligned memory word
- RdW  input  5  destination register
- PCPlus4W  input  32  link value
- Rs1D  input  5  Decode read address 1
- Rs2D  input  5  Decode read address 2
- RD1D  output  32  read data 1
- RD2D  output  32  read data 2
- ResultW  output  32  final writeback value, also feeds the forwarding mux
- WeW  output  1  effective write enable = ValidW & RegWriteW & (RdW != 0)
- InstRet  output  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Result select (combinational):
  - ResultSrcW 00 or 11 -> ALUResultW.
  - 10 -> PCPlus4W.
  - 01 -> LoadDataW.
- Load formatting, with off = ALUResultW[1:0]:
  - LB / LBU: byte = ReadDataW[8*off+7 : 8*off]; sign-extend for LB, zero-extend for LBU.
  - LH / LHU: halfword selected by off[1] (upper when 1); off[0] is ignored. Sign-extend for LH, zero-extend for LHU.
  - LW and reserved funct3 (011, 110, 111): ReadDataW unchanged.
- Register array:
  - 31 x 32-bit registers x1..x31.
  - x0 is not stored; it reads 0 always.
- Write:
  - On rising clk when WeW=1 and reset=0, regs[RdW] <= ResultW.
  - A write to x0 is discarded.
  - Bubbles (ValidW=0) never write, regardless of RegWriteW.
- Read (combinational):
  - Rs == 0 -> 0.
  - Otherwise, if BYPASS=1 and WeW=1 and Rs == RdW -> ResultW.
  - Otherwise -> regs[Rs].
  - Both ports may hit the bypass simultaneously.
- InstRet:
  - Increments by 1 on each rising clk with ValidW=1, whether or not the instruction writes a register.
  - Wraps from all-ones to 0 with no flag.
- Reset (synchronous, dominates everything in the same edge):
  - All registers cleared to 0; InstRet = 0.
  - Any write or increment presented in the reset cycle is discarded.
  - After the reset edge, RD1D = RD2D = 0 for every address.
  - ResultW and WeW remain combinational functions of their inputs during reset. With reset asserted, the array is not written even if WeW=1.
- Latency:
  - A value written at edge N is visible from the array after edge N.
  - With BYPASS=1 it is also visible combinationally in the cycle before edge N.
  - With BYPASS=0, same-cycle reads return the old value.
- No stalls or handshakes. The upstream MEM/WB register guarantees the inputs are stable for the whole cycle.

Test Plan:
- Reset/x0:
  - Assert reset for 1 cycle, then read x1..x31 -> all 0, InstRet=0.
  - Write 0xDEADBEEF to x0 with ValidW=RegWriteW=1 -> WeW=0; RD1D for Rs1D=0 stays 0.
- Result mux:
  - ALUResultW=0x1234, ResultSrcW=00, RdW=5 -> x5=0x1234.
  - ResultSrcW=10, PCPlus4W=0x80 -> x5=0x80.
  - ResultSrcW=11 -> ALUResultW.
- Loads, ReadDataW=0x80F1_7F82:
  - LB, off=0 -> 0xFFFFFF82. LBU, off=0 -> 0x00000082.
  - LB, off=1 -> 0x0000007F. LB, off=3 -> 0xFFFFFF80.
  - LH, off=2 -> 0xFFFF80F1. LHU, off=0 -> 0x00007F82. LH, off=3 -> 0xFFFF80F1.
  - LW -> 0x80F17F82. funct3=110 -> 0x80F17F82.
- Bypass:
  - With BYPASS=1, write x7=0xAAAA while Rs1D=Rs2D=7 -> both read 0xAAAA in the same cycle.
  - With BYPASS=0 -> old value that cycle, 0xAAAA next cycle.
  - A bubble (ValidW=0, RegWriteW=1) to x7 -> no bypass, no write.
- InstRet:
  - 10 cycles ValidW=1 interleaved with 3 bubbles -> InstRet=10.
  - Preload near wrap (INSTRET_WIDTH=4 build): 15 then one retire -> 0.
- Reset mid-operation:
  - Assert reset in the same cycle as a write x9=0x55 and ValidW=1 -> after the edge, x9=0 and InstRet=0.
  - Deassert reset, then write again -> x9=0x55.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: formats the WB result, commits it to x1..x31, serves two Decode read ports, counts retirements.
// Result/reads are combinational; writes and InstRet update on the next edge; no handshakes, never stalls.
module wb_regfile #(
  parameter bit BYPASS        = 1'b1,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ValidW,
  input  logic                     RegWriteW,
  input  logic [1:0]               ResultSrcW,
  input  logic [2:0]               LoadFunct3W,
  input  logic [31:0]              ALUResultW,
  input  logic [31:0]              ReadDataW,
  input  logic [4:0]               RdW,
  input  logic [31:0]              PCPlus4W,
  input  logic [4:0]               Rs1D,
  input  logic [4:0]               Rs2D,
  output logic [31:0]              RD1D,
  output logic [31:0]              RD2D,
  output logic [31:0]              ResultW,
  output logic                     WeW,
  output logic [INSTRET_WIDTH-1:0] InstRet
);

  logic [31:0]              regs_q [31:1];
  logic [31:0]              regs_d [31:1];
  logic [INSTRET_WIDTH-1:0] instret_q;
  logic [INSTRET_WIDTH-1:0] instret_d;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Memory returns the aligned word; the low address bits pick the lane.
  always_comb begin
    load_byte = 8'h00;
    case (ALUResultW[1:0])
      2'd0:    load_byte = ReadDataW[7:0];
      2'd1:    load_byte = ReadDataW[15:8];
      2'd2:    load_byte = ReadDataW[23:16];
      default: load_byte = ReadDataW[31:24];
    endcase
  end

  always_comb begin
    load_half = ALUResultW[1] ? ReadDataW[31:16] : ReadDataW[15:0];
  end

  always_comb begin
    load_data = ReadDataW;
    case (LoadFunct3W)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = ReadDataW;
    endcase
  end

  always_comb begin
    ResultW = ALUResultW;
    case (ResultSrcW)
      2'b01:   ResultW = load_data;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  always_comb begin
    WeW = ValidW && RegWriteW && (RdW != 5'd0);
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = (WeW && (RdW == 5'(i))) ? ResultW : regs_q[i];
    end
  end

  always_comb begin
    instret_d = ValidW ? instret_q + 1'b1 : instret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
      instret_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      instret_q <= instret_d;
    end
  end

  // x0 has no storage; the write-through path only exists when BYPASS is set.
  always_comb begin
    RD1D = 32'h0;
    if (Rs1D != 5'd0) begin
      if (BYPASS && WeW && (Rs1D == RdW)) RD1D = ResultW;
      else                                RD1D = regs_q[Rs1D];
    end
  end

  always_comb begin
    RD2D = 32'h0;
    if (Rs2D != 5'd0) begin
      if (BYPASS && WeW && (Rs2D == RdW)) RD2D = ResultW;
      else                                RD2D = regs_q[Rs2D];
    end
  end

  assign InstRet = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed steps plus random traffic against a behavioural register/counter model.
// Checks sampled at negedge, model updated at posedge, so one comparison per cycle per output.
// No handshakes on the DUT; the bench drives every input every cycle and never waits on the design.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        valid_w;
    logic        reg_write_w;
    logic [1:0]  result_src_w;
    logic [2:0]  load_funct3_w;
    logic [31:0] alu_result_w;
    logic [31:0] read_data_w;
    logic [4:0]  rd_w;
    logic [31:0] pc_plus4_w;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;

    logic [31:0] rd1_a, rd2_a, res_a;
    logic        we_a;
    logic [63:0] instret_a;
    logic [31:0] rd1_b, rd2_b, res_b;
    logic        we_b;
    logic [63:0] instret_b;
    logic [31:0] rd1_c, rd2_c, res_c;
    logic        we_c;
    logic [3:0]  instret_c;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0]     m_regs [0:31];
    longint unsigned m_instret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    wb_regfile #(.BYPASS(1'b1), .INSTRET_WIDTH(64)) dut_a (
        .clk(clk), .reset(reset), .ValidW(valid_w), .RegWriteW(reg_write_w),
        .ResultSrcW(result_src_w), .LoadFunct3W(load_funct3_w), .ALUResultW(alu_result_w),
        .ReadDataW(read_data_w), .RdW(rd_w), .PCPlus4W(pc_plus4_w), .Rs1D(rs1_d), .Rs2D(rs2_d),
        .RD1D(rd1_a), .RD2D(rd2_a), .ResultW(res_a), .WeW(we_a), .InstRet(instret_a));

    wb_regfile #(.BYPASS(1'b0), .INSTRET_WIDTH(64)) dut_b (
        .clk(clk), .reset(reset), .ValidW(valid_w), .RegWriteW(reg_write_w),
        .ResultSrcW(result_src_w), .LoadFunct3W(load_funct3_w), .ALUResultW(alu_result_w),
        .ReadDataW(read_data_w), .RdW(rd_w), .PCPlus4W(pc_plus4_w), .Rs1D(rs1_d), .Rs2D(rs2_d),
        .RD1D(rd1_b), .RD2D(rd2_b), .ResultW(res_b), .WeW(we_b), .InstRet(instret_b));

    wb_regfile #(.BYPASS(1'b1), .INSTRET_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .ValidW(valid_w), .RegWriteW(reg_write_w),
        .ResultSrcW(result_src_w), .LoadFunct3W(load_funct3_w), .ALUResultW(alu_result_w),
        .ReadDataW(read_data_w), .RdW(rd_w), .PCPlus4W(pc_plus4_w), .Rs1D(rs1_d), .Rs2D(rs2_d),
        .RD1D(rd1_c), .RD2D(rd2_c), .ResultW(res_c), .WeW(we_c), .InstRet(instret_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Writeback value from the ISA rules, using shifts and arithmetic on lane values.
    function automatic logic [31:0] m_result();
        int unsigned off, b, h;
        off = alu_result_w % 4;
        b   = (read_data_w >> (8 * off)) & 32'hFF;
        h   = (read_data_w >> (16 * (off / 2))) & 32'hFFFF;
        if (result_src_w == 2'b10) return pc_plus4_w;
        if (result_src_w != 2'b01) return alu_result_w;
        case (load_funct3_w)
            3'd0:    return (b >= 128)   ? 32'(b) - 32'd256   : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return read_data_w;
        endcase
    endfunction

    function automatic logic m_we();
        return valid_w && reg_write_w && (rd_w != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs, input bit bypass);
        if (rs == 0) return 32'h0;
        if (bypass && m_we() && rs == rd_w) return m_result();
        return m_regs[rs];
    endfunction

    task automatic check_now();
        @(negedge clk);
        chk("result", res_a, m_result());
        chk("we", we_a, m_we());
        chk("rd1_byp", rd1_a, m_read(rs1_d, 1'b1));
        chk("rd2_byp", rd2_a, m_read(rs2_d, 1'b1));
        chk("rd1_nobyp", rd1_b, m_read(rs1_d, 1'b0));
        chk("rd2_nobyp", rd2_b, m_read(rs2_d, 1'b0));
        chk("instret64", instret_a, 64'(m_instret));
        chk("instret4", instret_c, 64'(4'(m_instret)));
    endtask

    task automatic tick();
        logic        we;
        logic [31:0] res;
        we  = m_we();
        res = m_result();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_instret = 0;
        end else begin
            if (we) m_regs[rd_w] = res;
            if (valid_w) m_instret = m_instret + 1;
        end
        #1;
    endtask

    task automatic set_op(input logic v, input logic rw, input logic [1:0] src, input logic [4:0] rd,
                          input logic [31:0] alu);
        valid_w = v; reg_write_w = rw; result_src_w = src; rd_w = rd; alu_result_w = alu;
    endtask

    task automatic idle_read(input logic [4:0] a, input logic [4:0] b);
        set_op(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        rs1_d = a; rs2_d = b;
    endtask

    logic [2:0]  ld_f3  [9] = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd1, 3'd5, 3'd1, 3'd2, 3'd6};
    logic [1:0]  ld_off [9] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    logic [31:0] ld_exp [9] = '{32'hFFFFFF82, 32'h00000082, 32'h0000007F, 32'hFFFFFF80,
                                32'hFFFF80F1, 32'h00007F82, 32'hFFFF80F1, 32'h80F17F82, 32'h80F17F82};

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
        m_instret     = 0;
        reset         = 1'b1;
        load_funct3_w = 3'd2;
        read_data_w   = 32'h0;
        pc_plus4_w    = 32'h0;
        idle_read(5'd0, 5'd0);
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;

        // Reset state over the whole file.
        for (int i = 1; i < 32; i++) begin
            idle_read(5'(i), 5'(32 - i));
            check_now();
            chk("rst_rd1", rd1_a, 32'h0);
            tick();
        end
        chk("rst_instret", instret_a, 64'h0);

        // x0 write is dropped.
        set_op(1'b1, 1'b1, 2'b00, 5'd0, 32'hDEADBEEF);
        rs1_d = 5'd0;
        check_now();
        chk("x0_we", we_a, 1'b0);
        chk("x0_rd1", rd1_a, 32'h0);
        tick();

        // Result mux sources into x5.
        set_op(1'b1, 1'b1, 2'b00, 5'd5, 32'h1234);
        check_now(); tick();
        idle_read(5'd5, 5'd5); check_now();
        chk("mux_alu", rd1_a, 32'h1234);
        tick();
        set_op(1'b1, 1'b1, 2'b10, 5'd5, 32'h9999);
        pc_plus4_w = 32'h80;
        check_now(); tick();
        idle_read(5'd5, 5'd0); check_now();
        chk("mux_pc4", rd1_a, 32'h80);
        tick();
        set_op(1'b1, 1'b1, 2'b11, 5'd5, 32'h5678);
        check_now(); tick();
        idle_read(5'd5, 5'd0); check_now();
        chk("mux_rsvd", rd1_a, 32'h5678);
        tick();

        // Load formatting.
        read_data_w = 32'h80F17F82;
        for (int k = 0; k < 9; k++) begin
            set_op(1'b1, 1'b1, 2'b01, 5'd6, 32'h1000 | 32'(ld_off[k]));
            load_funct3_w = ld_f3[k];
            rs1_d = 5'd6;
            check_now();
            chk("load_fmt", res_a, ld_exp[k]);
            tick();
        end

        // Bypass versus no-bypass, then a bubble.
        set_op(1'b1, 1'b1, 2'b00, 5'd7, 32'h1111);
        check_now(); tick();
        set_op(1'b1, 1'b1, 2'b00, 5'd7, 32'hAAAA);
        rs1_d = 5'd7; rs2_d = 5'd7;
        check_now();
        chk("byp_rd1", rd1_a, 32'hAAAA);
        chk("byp_rd2", rd2_a, 32'hAAAA);
        chk("nobyp_old", rd1_b, 32'h1111);
        tick();
        idle_read(5'd7, 5'd7); check_now();
        chk("nobyp_new", rd1_b, 32'hAAAA);
        tick();
        set_op(1'b0, 1'b1, 2'b00, 5'd7, 32'hBBBB);
        check_now();
        chk("bubble_we", we_a, 1'b0);
        chk("bubble_rd", rd1_a, 32'hAAAA);
        tick();
        idle_read(5'd7, 5'd7); check_now();
        chk("bubble_nowr", rd1_a, 32'hAAAA);
        tick();

        // Retirement count with bubbles, and 4-bit wrap.
        reset = 1'b1; idle_read(5'd0, 5'd0); check_now(); tick(); reset = 1'b0;
        for (int k = 0; k < 13; k++) begin
            set_op((k % 4) != 3, 1'b0, 2'b00, 5'd0, 32'h0);
            check_now(); tick();
        end
        chk("instret_10", instret_a, 64'd10);
        for (int k = 0; k < 5; k++) begin
            set_op(1'b1, 1'b0, 2'b00, 5'd0, 32'h0);
            check_now(); tick();
        end
        chk("instret4_15", instret_c, 4'd15);
        check_now(); tick();
        chk("instret4_wrap", instret_c, 4'd0);

        // Reset dominates a same-edge write and retire.
        set_op(1'b1, 1'b1, 2'b00, 5'd9, 32'h55);
        reset = 1'b1;
        check_now(); tick();
        reset = 1'b0;
        idle_read(5'd9, 5'd9); check_now();
        chk("rst_x9", rd1_a, 32'h0);
        chk("rst_cnt", instret_a, 64'h0);
        tick();
        set_op(1'b1, 1'b1, 2'b00, 5'd9, 32'h55);
        check_now(); tick();
        idle_read(5'd9, 5'd0); check_now();
        chk("rewrite_x9", rd1_a, 32'h55);
        tick();

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            reset         = ($urandom_range(0, 59) == 0);
            valid_w       = ($urandom_range(0, 3) != 0);
            reg_write_w   = ($urandom_range(0, 4) != 0);
            result_src_w  = 2'($urandom);
            load_funct3_w = 3'($urandom);
            alu_result_w  = $urandom;
            read_data_w   = $urandom;
            pc_plus4_w    = $urandom;
            rd_w          = 5'($urandom);
            rs1_d         = ($urandom_range(0, 2) == 0) ? rd_w : 5'($urandom);
            rs2_d         = ($urandom_range(0, 2) == 0) ? rd_w : 5'($urandom);
            check_now();
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
